inst_queue: RTL and testbench



---
 rtl/inst_queue_pkg.sv | 26 ++
 rtl/inst_queue_fifo.sv | 84 ++++++++
 rtl/inst_queue.sv | 159 +++++++++++++++
 tb/tb_inst_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg
//   Shared constants and types for the instruction queue that sits between
//   the instruction cache and decode.
//   - INST_WIDTH / LINE_SIZE        : instruction and cache-line widths
//   - WORDS_PER_LINE / OFFSET_WIDTH : line geometry (16 words, 64-byte line)
//   - iq_entry_t                    : one queued instruction with its PC
//   - sat_inc                       : saturating 32-bit increment
package inst_queue_pkg;

  localparam int INST_WIDTH     = 32;
  localparam int LINE_SIZE      = 512;
  localparam int WORDS_PER_LINE = 16;
  localparam int OFFSET_WIDTH   = 6;
  localparam int PC_WIDTH       = 64;
  localparam int WORD_IDX_WIDTH = 4;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } iq_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
    return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/inst_queue_fifo.sv
// iq_fifo
//   Generic DEPTH-entry synchronous FIFO of iq_entry_t with flush.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     push_i/push_entry_i write one entry at the tail (ignored when full)
//     pop_i               drop the head entry (ignored when empty)
//     flush_i             empties the FIFO; overrides push and pop
//     head_o              registered contents of the head slot
//     full_o, empty_o     occupancy flags from the registered count
//     count_o             number of valid entries, 0..DEPTH
module iq_fifo
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  iq_entry_t                push_entry_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output iq_entry_t                head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  iq_entry_t        mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + PTR_W'(1);
      if (pop_ok)  head_d = head_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: slots are only observed once written.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[tail_q] <= push_entry_i;
  end

endmodule

// File: rtl/inst_queue.sv
// inst_queue
//   Takes one cache line + fetch PC from the icache, slices it into 32-bit
//   instructions from the PC's word offset to the end of the line, buffers
//   them in iq_fifo and hands them to decode one per cycle.
//   Optional build macro INST_QUEUE_PERF_EN adds three saturating 32-bit
//   performance counters (icache stall cycles, empty cycles, dequeues).
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     icache_valid_i/pc_i/data_i  line offered by the icache
//     stall_icache_o              line not accepted this cycle
//     iq_valid_o/pc_o/inst_o      head instruction towards decode
//     decode_ready_i              decode takes the head this cycle
//     squash_pipe_i               flush line buffer and FIFO
//     perf_*_cnt_o                counters (INST_QUEUE_PERF_EN only)
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int LINE_SIZE  = inst_queue_pkg::LINE_SIZE,
  parameter int INST_WIDTH = inst_queue_pkg::INST_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icache_valid_i,
  input  logic [63:0]           icache_pc_i,
  input  logic [LINE_SIZE-1:0]  icache_data_i,
  output logic                  stall_icache_o,
  output logic                  iq_valid_o,
  output logic [63:0]           iq_pc_o,
  output logic [INST_WIDTH-1:0] iq_inst_o,
  input  logic                  decode_ready_i,
  input  logic                  squash_pipe_i
`ifdef INST_QUEUE_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_empty_cnt_o,
  output logic [31:0]           perf_inst_cnt_o
`endif
);

  logic                      lb_vld_q,  lb_vld_d;
  logic [LINE_SIZE-1:0]      lb_line_q, lb_line_d;
  logic [63:OFFSET_WIDTH]    lb_base_q, lb_base_d;
  logic [WORD_IDX_WIDTH-1:0] lb_ptr_q,  lb_ptr_d;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(DEPTH):0]    fifo_count;
  iq_entry_t                 fifo_head;
  iq_entry_t                 push_entry;

  logic xfer;
  logic last;
  logic accept;
  logic push;
  logic pop;

  logic unused_pc_bits;
  assign unused_pc_bits = ^icache_pc_i[1:0];

  // Full-gating uses the registered count only: a dequeue in the same
  // cycle does not open a slot for the line buffer.
  assign xfer           = lb_vld_q && !fifo_full;
  assign last           = xfer && (lb_ptr_q == WORD_IDX_WIDTH'(WORDS_PER_LINE - 1));
  assign stall_icache_o = lb_vld_q && !last;
  assign accept         = icache_valid_i && !stall_icache_o && !squash_pipe_i;
  assign push           = xfer && !squash_pipe_i;
  assign pop            = !fifo_empty && decode_ready_i && !squash_pipe_i;

  assign push_entry.pc   = {lb_base_q, lb_ptr_q, 2'b00};
  assign push_entry.inst = lb_line_q[int'(lb_ptr_q) * INST_WIDTH +: INST_WIDTH];

  // Acceptance during the last transfer reloads the buffer directly, so
  // back-to-back lines stream without a bubble.
  always_comb begin
    lb_vld_d  = lb_vld_q;
    lb_line_d = lb_line_q;
    lb_base_d = lb_base_q;
    lb_ptr_d  = lb_ptr_q;
    if (squash_pipe_i) begin
      lb_vld_d = 1'b0;
      lb_ptr_d = '0;
    end else if (accept) begin
      lb_vld_d  = 1'b1;
      lb_line_d = icache_data_i;
      lb_base_d = icache_pc_i[63:OFFSET_WIDTH];
      lb_ptr_d  = icache_pc_i[OFFSET_WIDTH-1:2];
    end else if (push) begin
      if (last) lb_vld_d = 1'b0;
      else      lb_ptr_d = lb_ptr_q + WORD_IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_vld_q  <= 1'b0;
      lb_line_q <= '0;
      lb_base_q <= '0;
      lb_ptr_q  <= '0;
    end else begin
      lb_vld_q  <= lb_vld_d;
      lb_line_q <= lb_line_d;
      lb_base_q <= lb_base_d;
      lb_ptr_q  <= lb_ptr_d;
    end
  end

  iq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (squash_pipe_i),
    .head_o       (fifo_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

  assign iq_valid_o = !fifo_empty;
  assign iq_pc_o    = fifo_head.pc;
  assign iq_inst_o  = fifo_head.inst;

`ifdef INST_QUEUE_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_empty_q, perf_empty_d;
  logic [31:0] perf_inst_q,  perf_inst_d;

  // Squash deliberately leaves the counters alone.
  always_comb begin
    perf_stall_d = sat_inc(perf_stall_q, icache_valid_i && stall_icache_o);
    perf_empty_d = sat_inc(perf_empty_q, (fifo_count == '0) && !lb_vld_q);
    perf_inst_d  = sat_inc(perf_inst_q, pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_empty_q <= '0;
      perf_inst_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_empty_q <= perf_empty_d;
      perf_inst_q  <= perf_inst_d;
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_empty_cnt_o = perf_empty_q;
  assign perf_inst_cnt_o  = perf_inst_q;
`else
  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;
`endif

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         icache_valid_i = 1'b0;
  logic [63:0]  icache_pc_i = '0;
  logic [511:0] icache_data_i = '0;
  logic         stall_icache_o;
  logic         iq_valid_o;
  logic [63:0]  iq_pc_o;
  logic [31:0]  iq_inst_o;
  logic         decode_ready_i = 1'b0;
  logic         squash_pipe_i = 1'b0;
`ifdef INST_QUEUE_PERF_EN
  logic [31:0]  perf_stall_cnt_o;
  logic [31:0]  perf_empty_cnt_o;
  logic [31:0]  perf_inst_cnt_o;
`endif

  inst_queue #(.DEPTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_valid_i (icache_valid_i),
    .icache_pc_i    (icache_pc_i),
    .icache_data_i  (icache_data_i),
    .stall_icache_o (stall_icache_o),
    .iq_valid_o     (iq_valid_o),
    .iq_pc_o        (iq_pc_o),
    .iq_inst_o      (iq_inst_o),
    .decode_ready_i (decode_ready_i),
    .squash_pipe_i  (squash_pipe_i)
`ifdef INST_QUEUE_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_empty_cnt_o (perf_empty_cnt_o),
    .perf_inst_cnt_o  (perf_inst_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    int          cyc;
  } rec_t;
  rec_t got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every instruction decode actually takes.
  always @(negedge clk) begin
    if (rst_n && iq_valid_o && decode_ready_i && !squash_pipe_i)
      got_q.push_back('{iq_pc_o, iq_inst_o, cyc});
  end

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_line(input string tag, input logic [63:0] pc, input logic [31:0] base);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 16; k++) icache_data_i[32*k +: 32] = base + 32'(k);
    icache_pc_i    = pc;
    icache_valid_i = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!stall_icache_o && !squash_pipe_i) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    icache_valid_i = 1'b0;
    check_vec({tag, "_accept"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_count(input int n);
    for (int i = 0; i < 400 && got_q.size() < n; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag, input logic [63:0] pc0, input logic [31:0] inst0,
                              input int n, input bit consec);
    int m;
    check_vec({tag, "_count"}, 64'(got_q.size()), 64'(n));
    m = (got_q.size() < n) ? got_q.size() : n;
    for (int i = 0; i < m; i++) begin
      check_vec($sformatf("%s_pc%0d", tag, i), got_q[i].pc, pc0 + 64'(4 * i));
      check_vec($sformatf("%s_inst%0d", tag, i), 64'(got_q[i].inst), 64'(inst0 + 32'(i)));
      if (consec && i > 0)
        check_vec($sformatf("%s_gap%0d", tag, i), 64'(got_q[i].cyc - got_q[i-1].cyc), 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    #1;
    check_vec("rst_valid", 64'(iq_valid_o), 64'd0);
    check_vec("rst_stall", 64'(stall_icache_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // full line from offset 0, latency and streaming
    decode_ready_i = 1'b1;
    got_q.delete();
    send_line("l1", 64'h1000, 32'hA000_0000);
    check_vec("l1_lat1_valid", 64'(iq_valid_o), 64'd0);
    @(posedge clk);
    #1;
    check_vec("l1_lat2_valid", 64'(iq_valid_o), 64'd1);
    check_vec("l1_lat2_pc", iq_pc_o, 64'h1000);
    wait_count(16);
    check_stream("l1", 64'h1000, 32'hA000_0000, 16, 1'b1);

    // line starting at word 14
    got_q.delete();
    send_line("l2", 64'h2038, 32'hA100_0000);
    check_vec("l2_stall_w14", 64'(stall_icache_o), 64'd1);
    @(posedge clk);
    #1;
    check_vec("l2_stall_w15", 64'(stall_icache_o), 64'd0);
    wait_count(2);
    check_stream("l2", 64'h2038, 32'hA100_000E, 2, 1'b1);

    // backpressure from decode
    decode_ready_i = 1'b0;
    got_q.delete();
    send_line("l3", 64'h3000, 32'hA200_0000);
    repeat (12) @(posedge clk);
    #1;
    check_vec("l3_full_valid", 64'(iq_valid_o), 64'd1);
    check_vec("l3_full_pc", iq_pc_o, 64'h3000);
    check_vec("l3_full_inst", 64'(iq_inst_o), 64'hA200_0000);
    icache_pc_i    = 64'h3040;
    icache_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_vec($sformatf("l3_stall%0d", i), 64'(stall_icache_o), 64'd1);
    end
    @(posedge clk);
    #1;
    icache_valid_i = 1'b0;
    check_vec("l3_none_yet", 64'(got_q.size()), 64'd0);
    decode_ready_i = 1'b1;
    wait_count(16);
    check_stream("l3", 64'h3000, 32'hA200_0000, 16, 1'b1);

    // back-to-back lines
    got_q.delete();
    send_line("b2b_a", 64'h4000, 32'hB000_0000);
    send_line("b2b_b", 64'h4040, 32'hB000_0010);
    wait_count(32);
    check_stream("b2b", 64'h4000, 32'hB000_0000, 32, 1'b1);

    // squash with 5 queued, a line buffered and a new line offered
    decode_ready_i = 1'b0;
    got_q.delete();
    send_line("sq_a", 64'h4800, 32'hB100_0000);
    repeat (5) @(posedge clk);
    #1;
    check_vec("sq_pre_valid", 64'(iq_valid_o), 64'd1);
    check_vec("sq_pre_pc", iq_pc_o, 64'h4800);
    icache_pc_i    = 64'h7000;
    icache_valid_i = 1'b1;
    squash_pipe_i  = 1'b1;
    @(posedge clk);
    #1;
    squash_pipe_i  = 1'b0;
    icache_valid_i = 1'b0;
    check_vec("sq_post_valid", 64'(iq_valid_o), 64'd0);
    check_vec("sq_post_stall", 64'(stall_icache_o), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check_vec("sq_late_valid", 64'(iq_valid_o), 64'd0);
    check_vec("sq_none", 64'(got_q.size()), 64'd0);
    decode_ready_i = 1'b1;
    send_line("sq_b", 64'h5000, 32'hC000_0000);
    wait_count(16);
    check_stream("sq", 64'h5000, 32'hC000_0000, 16, 1'b1);

    // asynchronous reset mid-line
    got_q.delete();
    send_line("rs_a", 64'h6800, 32'hD000_0000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_vec("rs_valid", 64'(iq_valid_o), 64'd0);
    check_vec("rs_stall", 64'(stall_icache_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    send_line("rs_b", 64'h6000, 32'hD100_0000);
    wait_count(16);
    check_stream("rs", 64'h6000, 32'hD100_0000, 16, 1'b1);
`ifdef INST_QUEUE_PERF_EN
    check_vec("perf_inst", 64'(perf_inst_cnt_o), 64'd16);
    check_vec("perf_stall", 64'(perf_stall_cnt_o), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
